legv8_decode_stage: RTL and testbench
=====================================

Name: legv8_decode_stage

Overview:
- Registered instruction-decode pipeline stage for the LEGv8 datapath. Sits between the fetch stage and the execute/register-file stage.
- Decodes the supported LEGv8 subset into register indices, a sign/zero-extended immediate and the control bundle.
- Uses valid/ready handshakes on both sides, a synchronous flush, and a load-use interlock that holds dependent instructions after an LDUR.
- Replaces the combinational decoder with a parametrised, pipelined stage.

Parameters:
DATA_W, 64, width of the extended immediate and of the datapath
PC_W, 64, width of the PC carried alongside the instruction
REG_AW, 5, register index width; 5-bit instruction fields are zero-extended to REG_AW (REG_AW >= 5)
LU_STALL, 1, cycles a load-dependent instruction is held after an LDUR leaves the stage (0 disables the interlock)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; kills the output entry and the interlock
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts this cycle
instruction  in  32  instruction word
pc_in  in  PC_W  PC of instruction
out_valid  out  1  decoded entry valid
out_ready  in  1  downstream accepts
pc_out  out  PC_W  registered PC
reg1  out  REG_AW  Rn, bits 9:5
reg2  out  REG_AW  Rm (R-type, bits 20:16) or Rt (D/CB-type, bits 4:0)
wreg  out  REG_AW  Rd/Rt, bits 4:0
se  out  DATA_W  extended immediate
ALUsrc, Ubranch, Branch, BranchNZ, MemRead, MemWrite, MemToReg, RegWrite, illegal  out  1 each  control bits
ALUop  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0. All data and control outputs are 0. The interlock counter and captured load register are 0.
- Decode, checked in this priority order:
  - B: [31:26]=000101. Ubranch=1, ALUop=0111. se = sign-extended [25:0].
  - CBZ: [31:24]=10110100. Branch=1, ALUop=0111, reg2=Rt. se = sign-extended [23:5].
  - CBNZ: [31:24]=10110101. Same as CBZ, with BranchNZ=1 instead of Branch.
  - STUR: [31:21]=11111000000. MemWrite=1, ALUsrc=1, ALUop=0010. reg1=Rn, reg2=Rt. se = sign-extended [20:12].
  - LDUR: [31:21]=11111000010. MemRead=1, MemToReg=1, RegWrite=1, ALUsrc=1, ALUop=0010, wreg=Rt. se = sign-extended [20:12].
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 on [31:21]: RegWrite=1, ALUop per the table above. reg1, reg2 and wreg from Rn, Rm and Rd.
  - ADDI / SUBI: [31:22]=1001000100 / 1101000100. ALUsrc=1, RegWrite=1, ALUop 0010 / 0110. se = zero-extended [21:10].
  - Any other encoding: illegal=1, all other controls 0, entry still valid so downstream can trap.
- Unused register-index fields are driven 0.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hold && !flush.
  - The output register loads on in_valid && in_ready.
  - The output register clears out_valid when out_valid && out_ready with no new load.
  - Latency is 1 cycle. With out_ready held high, throughput is one instruction per cycle.
  - Outputs are stable while out_valid && !out_ready.
- Load-use interlock:
  - When an LDUR transfers out (out_valid && out_ready) with Rt != 31, the stage captures lu_reg=Rt and sets lu_cnt=LU_STALL.
  - lu_cnt decrements by 1 every cycle it is non-zero. A new LDUR transfer reloads it.
  - hold = (lu_cnt != 0) && the presented instruction reads lu_reg via reg1 or reg2 as actually used by its format.
  - Reads of X31 never hold.
  - Independent instructions are not held.
- Flush:
  - On the next edge: out_valid=0, lu_cnt=0. The instruction presented that cycle is not accepted.
  - Flush has priority over load and transfer.
- Simultaneous transfer-out and accept: the new entry replaces the old in the same edge, with no bubble.
- Reset mid-operation: the pending entry is dropped. No output is generated until the first accept after rst_n deasserts.

Test Plan:
- Reset, then ADD X3,X1,X2 (0x8B020023) with out_ready=1 → next cycle out_valid=1, reg1=1, reg2=2, wreg=3, ALUop=0010, RegWrite=1, all other controls 0.
- LDUR X5,[X1,#-8] (0xF85F8025) → se=0xFFFFFFFFFFFFFFF8, MemRead=MemToReg=ALUsrc=RegWrite=1. Follow with SUB X6,X5,X2 (0xCB0200A6) → in_ready=0 for 1 cycle, then accepted. With Rm=X7 instead, no hold.
- CBNZ X4,#-2 (0xB5FFFFC4) → BranchNZ=1, Branch=0, reg2=4, ALUop=0111, se=all ones except bit 0 (-2).
- Hold out_ready=0 with B #+16 (0x14000010) in the output register → in_ready=0 and outputs stable. Then release → se=0x10, Ubranch=1.
- Assert flush with a valid entry and lu_cnt=1 → out_valid=0 next cycle, dependent instruction accepted without hold.
- Encoding 0x00000000 → out_valid=1, illegal=1, all other controls 0. Pulse rst_n low mid-hold → out_valid=0 immediately, lu_cnt=0.

Source files
------------

// File: rtl/legv8_decode_if.sv
// legv8_decode_if: fetch-side and execute-side handshake bundle of the LEGv8 decode stage
interface legv8_decode_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [PC_W-1:0]   pc_in;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_out;
    logic [REG_AW-1:0] reg1;
    logic [REG_AW-1:0] reg2;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] se;
    logic              ALUsrc;
    logic              Ubranch;
    logic              Branch;
    logic              BranchNZ;
    logic              MemRead;
    logic              MemWrite;
    logic              MemToReg;
    logic              RegWrite;
    logic              illegal;
    logic [3:0]        ALUop;

    modport master (
        output flush, in_valid, instruction, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, reg1, reg2, wreg, se,
               ALUsrc, Ubranch, Branch, BranchNZ, MemRead, MemWrite, MemToReg, RegWrite, illegal, ALUop
    );

    modport slave (
        input  flush, in_valid, instruction, pc_in, out_ready,
        output in_ready, out_valid, pc_out, reg1, reg2, wreg, se,
               ALUsrc, Ubranch, Branch, BranchNZ, MemRead, MemWrite, MemToReg, RegWrite, illegal, ALUop
    );
endinterface

// File: rtl/legv8_decode_stage.sv
// legv8_decode_stage: registered LEGv8 decoder with valid/ready handshake, flush and load-use interlock
module legv8_decode_stage #(
    parameter int DATA_W   = 64,
    parameter int PC_W     = 64,
    parameter int REG_AW   = 5,
    parameter int LU_STALL = 1
) (
    input logic           clk,
    input logic           rst_n,
    legv8_decode_if.slave bus
);
    localparam int CNT_W = LU_STALL > 0 ? $clog2(LU_STALL + 1) : 1;

    typedef struct packed {
        logic [REG_AW-1:0] reg1;
        logic [REG_AW-1:0] reg2;
        logic [REG_AW-1:0] wreg;
        logic [DATA_W-1:0] se;
        logic              alu_src;
        logic              ubranch;
        logic              branch;
        logic              branch_nz;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic              illegal;
        logic [3:0]        alu_op;
    } ctl_t;

    logic [31:0]       ins;
    logic [10:0]       op;
    logic [REG_AW-1:0] rn, rm, rd;
    ctl_t              d, q;
    logic              use1, use2;
    logic              hold, accept, out_valid;
    logic [PC_W-1:0]   pc_q;
    logic [CNT_W-1:0]  lu_cnt;
    logic [REG_AW-1:0] lu_reg;

    assign ins = bus.instruction;
    assign op  = ins[31:21];
    assign rn  = REG_AW'(ins[9:5]);
    assign rm  = REG_AW'(ins[20:16]);
    assign rd  = REG_AW'(ins[4:0]);

    // priority decode of the presented instruction; use1/use2 mark which read ports the format really uses
    always_comb begin
        d    = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        if (ins[31:26] == 6'b000101) begin
            d.ubranch = 1'b1;
            d.alu_op  = 4'b0111;
            d.se      = {{(DATA_W-26){ins[25]}}, ins[25:0]};
        end else if (ins[31:25] == 7'b1011010) begin
            d.branch    = !ins[24];
            d.branch_nz = ins[24];
            d.alu_op    = 4'b0111;
            d.reg2      = rd;
            use2        = 1'b1;
            d.se        = {{(DATA_W-19){ins[23]}}, ins[23:5]};
        end else if (op == 11'b11111000000) begin
            d.mem_write = 1'b1;
            d.alu_src   = 1'b1;
            d.alu_op    = 4'b0010;
            d.reg1      = rn;
            d.reg2      = rd;
            use1        = 1'b1;
            use2        = 1'b1;
            d.se        = {{(DATA_W-9){ins[20]}}, ins[20:12]};
        end else if (op == 11'b11111000010) begin
            d.mem_read   = 1'b1;
            d.mem_to_reg = 1'b1;
            d.reg_write  = 1'b1;
            d.alu_src    = 1'b1;
            d.alu_op     = 4'b0010;
            d.reg1       = rn;
            d.wreg       = rd;
            use1         = 1'b1;
            d.se         = {{(DATA_W-9){ins[20]}}, ins[20:12]};
        end else if (op == 11'b10001011000 || op == 11'b11001011000 ||
                     op == 11'b10001010000 || op == 11'b10101010000) begin
            d.reg_write = 1'b1;
            d.alu_op    = op == 11'b10001011000 ? 4'b0010 :
                          op == 11'b11001011000 ? 4'b0110 :
                          op == 11'b10001010000 ? 4'b0000 : 4'b0001;
            d.reg1      = rn;
            d.reg2      = rm;
            d.wreg      = rd;
            use1        = 1'b1;
            use2        = 1'b1;
        end else if (ins[31:22] == 10'b1001000100 || ins[31:22] == 10'b1101000100) begin
            d.alu_src   = 1'b1;
            d.reg_write = 1'b1;
            d.alu_op    = ins[30] ? 4'b0110 : 4'b0010;
            d.reg1      = rn;
            d.wreg      = rd;
            use1        = 1'b1;
            d.se        = {{(DATA_W-12){1'b0}}, ins[21:10]};
        end else begin
            d.illegal = 1'b1;
        end
    end

    // lu_reg is never X31, so a read of X31 can never match it
    assign hold   = (lu_cnt != '0) && ((use1 && d.reg1 == lu_reg) || (use2 && d.reg2 == lu_reg));
    assign bus.in_ready = (!out_valid || bus.out_ready) && !hold && !bus.flush;
    assign accept = bus.in_valid && bus.in_ready;

    // output register: flush kills the entry, accept loads (replacing a departing entry), drain clears valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            pc_q      <= '0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            q         <= d;
            pc_q      <= bus.pc_in;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // load-use interlock: arm when an LDUR with a real destination leaves, then count down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt <= '0;
            lu_reg <= '0;
        end else if (bus.flush) begin
            lu_cnt <= '0;
        end else if (out_valid && bus.out_ready && q.mem_read && q.wreg != REG_AW'(5'd31)) begin
            lu_cnt <= CNT_W'(LU_STALL);
            lu_reg <= q.wreg;
        end else if (lu_cnt != '0) begin
            lu_cnt <= lu_cnt - 1'b1;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.pc_out    = pc_q;
    assign bus.reg1      = q.reg1;
    assign bus.reg2      = q.reg2;
    assign bus.wreg      = q.wreg;
    assign bus.se        = q.se;
    assign bus.ALUsrc    = q.alu_src;
    assign bus.Ubranch   = q.ubranch;
    assign bus.Branch    = q.branch;
    assign bus.BranchNZ  = q.branch_nz;
    assign bus.MemRead   = q.mem_read;
    assign bus.MemWrite  = q.mem_write;
    assign bus.MemToReg  = q.mem_to_reg;
    assign bus.RegWrite  = q.reg_write;
    assign bus.illegal   = q.illegal;
    assign bus.ALUop     = q.alu_op;
endmodule

// File: tb/tb_legv8_decode_stage.sv
// tb_legv8_decode_stage: directed-vector bench for the LEGv8 decode stage
module tb_legv8_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;

    legv8_decode_if bus();
    legv8_decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [31:0] I_ADD     = 32'h8B020023;
    localparam logic [31:0] I_LDUR    = 32'hF85F8025;
    localparam logic [31:0] I_LDUR31  = 32'hF85F803F;
    localparam logic [31:0] I_SUB_DEP = 32'hCB0200A6;
    localparam logic [31:0] I_SUB_IND = 32'hCB0200E6;
    localparam logic [31:0] I_SUB_RM5 = 32'hCB050046;
    localparam logic [31:0] I_ADD_X31 = 32'h8B0203E3;
    localparam logic [31:0] I_CBNZ    = 32'hB5FFFFC4;
    localparam logic [31:0] I_B       = 32'h14000010;

    // {ALUsrc,Ubranch,Branch,BranchNZ,MemRead,MemWrite,MemToReg,RegWrite,illegal,ALUop}
    localparam logic [12:0] C_ADD  = {9'b000000010, 4'b0010};
    localparam logic [12:0] C_SUB  = {9'b000000010, 4'b0110};
    localparam logic [12:0] C_LDUR = {9'b100010110, 4'b0010};
    localparam logic [12:0] C_CBNZ = {9'b000100000, 4'b0111};
    localparam logic [12:0] C_B    = {9'b010000000, 4'b0111};
    localparam logic [12:0] C_ILL  = {9'b000000001, 4'b0000};

    function automatic logic [12:0] ctl();
        return {bus.ALUsrc, bus.Ubranch, bus.Branch, bus.BranchNZ, bus.MemRead, bus.MemWrite,
                bus.MemToReg, bus.RegWrite, bus.illegal, bus.ALUop};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic rdy);
        bus.in_valid    = v;
        bus.instruction = i;
        bus.pc_in       = {32'hC0DE0000, i};
        bus.out_ready   = rdy;
        #1;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        rst_n = 1'b0;
        tick();
        tick();
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        vecs++; if (ctl() !== 13'h0) begin errs++; $display("FAIL reset_ctl got %h want 0", ctl()); end
        vecs++; if ({bus.reg1, bus.reg2, bus.wreg, bus.se, bus.pc_out} !== '0) begin errs++; $display("FAIL reset_data got nonzero want 0"); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b1, I_ADD, 1'b1);
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL add_in_ready got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL add_valid got %b want 1", bus.out_valid); end
        vecs++; if ({bus.reg1, bus.reg2, bus.wreg} !== {5'd1, 5'd2, 5'd3}) begin errs++; $display("FAIL add_regs got %0d/%0d/%0d want 1/2/3", bus.reg1, bus.reg2, bus.wreg); end
        vecs++; if (ctl() !== C_ADD) begin errs++; $display("FAIL add_ctl got %h want %h", ctl(), C_ADD); end
        vecs++; if (bus.pc_out !== 64'hC0DE00008B020023) begin errs++; $display("FAIL add_pc got %h want C0DE00008B020023", bus.pc_out); end
        vecs++; if (bus.se !== 64'h0) begin errs++; $display("FAIL add_se got %h want 0", bus.se); end
        tick();
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL add_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_load_use();
        drive(1'b1, I_LDUR, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.se !== 64'hFFFFFFFFFFFFFFF8) begin errs++; $display("FAIL ldur_se got %h want FFFFFFFFFFFFFFF8", bus.se); end
        vecs++; if (ctl() !== C_LDUR) begin errs++; $display("FAIL ldur_ctl got %h want %h", ctl(), C_LDUR); end
        vecs++; if ({bus.reg1, bus.reg2, bus.wreg} !== {5'd1, 5'd0, 5'd5}) begin errs++; $display("FAIL ldur_regs got %0d/%0d/%0d want 1/0/5", bus.reg1, bus.reg2, bus.wreg); end
        tick();
        drive(1'b1, I_SUB_DEP, 1'b1);
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL lu_hold_rn got %b want 0", bus.in_ready); end
        tick();
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL lu_held_valid got %b want 0", bus.out_valid); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL lu_release got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1 || bus.reg1 !== 5'd5 || bus.wreg !== 5'd6 || ctl() !== C_SUB) begin errs++; $display("FAIL lu_sub got v=%b rn=%0d rd=%0d ctl=%h want 1/5/6/%h", bus.out_valid, bus.reg1, bus.wreg, ctl(), C_SUB); end
        drive(1'b1, I_LDUR, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, I_SUB_IND, 1'b1);
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL lu_indep got %b want 1", bus.in_ready); end
        tick();
        drive(1'b1, I_LDUR, 1'b1);
        vecs++; if (bus.reg1 !== 5'd7) begin errs++; $display("FAIL lu_indep_rn got %0d want 7", bus.reg1); end
        tick();
        drive(1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, I_SUB_RM5, 1'b1);
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL lu_hold_rm got %b want 0", bus.in_ready); end
        tick();
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1 || bus.reg2 !== 5'd5) begin errs++; $display("FAIL lu_rm_sub got v=%b rm=%0d want 1/5", bus.out_valid, bus.reg2); end
        tick();
        drive(1'b1, I_LDUR31, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b1, I_ADD_X31, 1'b1);
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL lu_x31 got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b1);
        tick();
    endtask

    task automatic test_cbnz();
        drive(1'b1, I_CBNZ, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (ctl() !== C_CBNZ) begin errs++; $display("FAIL cbnz_ctl got %h want %h", ctl(), C_CBNZ); end
        vecs++; if ({bus.reg1, bus.reg2, bus.wreg} !== {5'd0, 5'd4, 5'd0}) begin errs++; $display("FAIL cbnz_regs got %0d/%0d/%0d want 0/4/0", bus.reg1, bus.reg2, bus.wreg); end
        vecs++; if (bus.se !== 64'hFFFFFFFFFFFFFFFE) begin errs++; $display("FAIL cbnz_se got %h want FFFFFFFFFFFFFFFE", bus.se); end
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, I_B, 1'b0);
        tick();
        drive(1'b1, I_ADD, 1'b0);
        vecs++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL stall_ready got v=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready); end
        tick();
        vecs++; if (bus.out_valid !== 1'b1 || bus.se !== 64'h10 || ctl() !== C_B || bus.wreg !== 5'd0) begin errs++; $display("FAIL stall_stable got v=%b se=%h ctl=%h rd=%0d want 1/10/%h/0", bus.out_valid, bus.se, ctl(), bus.wreg, C_B); end
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL stall_release got %b want 1", bus.in_ready); end
        tick();
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL stall_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, I_LDUR, 1'b1);
        tick();
        drive(1'b1, I_ADD, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0);
        vecs++; if (bus.out_valid !== 1'b1 || bus.wreg !== 5'd3 || ctl() !== C_ADD) begin errs++; $display("FAIL replace got v=%b rd=%0d ctl=%h want 1/3/%h", bus.out_valid, bus.wreg, ctl(), C_ADD); end
        bus.flush = 1'b1;
        drive(1'b1, I_SUB_DEP, 1'b0);
        vecs++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b want 0", bus.in_ready); end
        tick();
        bus.flush = 1'b0;
        drive(1'b1, I_SUB_DEP, 1'b1);
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL flush_lu got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1 || bus.wreg !== 5'd6) begin errs++; $display("FAIL flush_accept got v=%b rd=%0d want 1/6", bus.out_valid, bus.wreg); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, I_ADD, 1'b1);
        tick();
        vecs++; if (bus.out_valid !== 1'b1 || bus.wreg !== 5'd3) begin errs++; $display("FAIL b2b_0 got v=%b rd=%0d want 1/3", bus.out_valid, bus.wreg); end
        drive(1'b1, I_CBNZ, 1'b1);
        tick();
        vecs++; if (bus.out_valid !== 1'b1 || ctl() !== C_CBNZ) begin errs++; $display("FAIL b2b_1 got v=%b ctl=%h want 1/%h", bus.out_valid, ctl(), C_CBNZ); end
        drive(1'b1, I_B, 1'b1);
        tick();
        vecs++; if (bus.out_valid !== 1'b1 || bus.se !== 64'h10) begin errs++; $display("FAIL b2b_2 got v=%b se=%h want 1/10", bus.out_valid, bus.se); end
        drive(1'b0, 32'h0, 1'b1);
        tick();
        vecs++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL b2b_end got %b want 0", bus.out_valid); end
    endtask

    task automatic test_illegal_reset();
        drive(1'b1, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1 || ctl() !== C_ILL || bus.se !== 64'h0) begin errs++; $display("FAIL illegal got v=%b ctl=%h se=%h want 1/%h/0", bus.out_valid, ctl(), bus.se, C_ILL); end
        tick();
        drive(1'b1, I_LDUR, 1'b1);
        tick();
        drive(1'b1, I_ADD, 1'b1);
        tick();
        drive(1'b1, I_SUB_DEP, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errs++; $display("FAIL prereset_hold got v=%b rdy=%b want 1/0", bus.out_valid, bus.in_ready); end
        rst_n = 1'b0;
        #1;
        vecs++; if (bus.out_valid !== 1'b0 || bus.wreg !== 5'd0) begin errs++; $display("FAIL async_reset got v=%b rd=%0d want 0/0", bus.out_valid, bus.wreg); end
        vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_lu got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        tick();
        drive(1'b0, 32'h0, 1'b1);
        vecs++; if (bus.out_valid !== 1'b1 || bus.wreg !== 5'd6) begin errs++; $display("FAIL post_reset got v=%b rd=%0d want 1/6", bus.out_valid, bus.wreg); end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_cbnz();
        test_stall();
        test_flush();
        test_back_to_back();
        test_illegal_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end
endmodule
